// File: rtl/panel_scan_controller.sv
// Scan sequencer for the three-colour panel driver: per frame it loads brightness once,
// then for every row and PWM step it loads, shifts and latches one row of LED values.
module panel_scan_controller #(
   parameter int NUM_ROWS     = 16,
   parameter int PWM_STEPS    = 256,
   parameter int BITS_PER_ROW = 16,
   parameter int SHIFT_DIV    = 2,
   localparam int ROW_W       = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             enable,
   input  logic [7:0]       brightness_in,
   input  logic             brightness_update,
   output logic             shift,
   output logic             load_led_vals,
   output logic             load_brightness,
   output logic [7:0]       brightness,
   output logic [ROW_W-1:0] read_port_row_addr,
   output logic [7:0]       pwm_step,
   output logic             latch,
   output logic             blank,
   output logic [ROW_W-1:0] row_select,
   output logic             frame_done,
   output logic             busy
);

   localparam int DIV_W = $clog2(SHIFT_DIV);
   localparam int BIT_W = (BITS_PER_ROW > 1) ? $clog2(BITS_PER_ROW) : 1;

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_BRIGHT = 3'd1;
   localparam logic [2:0] S_SETUP  = 3'd2;
   localparam logic [2:0] S_LOAD   = 3'd3;
   localparam logic [2:0] S_SHIFT  = 3'd4;
   localparam logic [2:0] S_LATCH  = 3'd5;

   localparam logic [ROW_W-1:0] LAST_ROW  = ROW_W'(NUM_ROWS - 1);
   localparam logic [7:0]       LAST_STEP = 8'(PWM_STEPS - 1);
   localparam logic [DIV_W-1:0] LAST_DIV  = DIV_W'(SHIFT_DIV - 1);
   localparam logic [BIT_W-1:0] LAST_BIT  = BIT_W'(BITS_PER_ROW - 1);

   logic [2:0]       state;
   logic [ROW_W-1:0] row;
   logic [7:0]       step;
   logic [DIV_W-1:0] div_cnt;
   logic [BIT_W-1:0] bit_cnt;
   logic [7:0]       pending;
   // Set once a row has been latched in the current frame; outputs stay lit until the next latch.
   logic             lit;

   assign shift              = (state == S_SHIFT) && (div_cnt == '0);
   assign load_led_vals      = (state == S_LOAD);
   assign load_brightness    = (state == S_BRIGHT);
   assign latch              = (state == S_LATCH);
   assign blank              = ~lit | latch;
   assign busy               = (state != S_IDLE);
   assign frame_done         = latch && (row == LAST_ROW) && (step == LAST_STEP);
   assign read_port_row_addr = row;
   assign pwm_step           = step;

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= S_IDLE;
         row        <= '0;
         step       <= '0;
         div_cnt    <= '0;
         bit_cnt    <= '0;
         pending    <= '0;
         brightness <= '0;
         row_select <= '0;
         lit        <= 1'b0;
      end else begin
         if (brightness_update) pending <= brightness_in;
         case (state)
            S_IDLE: begin
               if (enable) begin
                  state      <= S_BRIGHT;
                  brightness <= pending;
               end
            end
            S_BRIGHT: state <= S_SETUP;
            S_SETUP:  state <= S_LOAD;
            S_LOAD: begin
               state   <= S_SHIFT;
               div_cnt <= '0;
               bit_cnt <= '0;
            end
            S_SHIFT: begin
               if (div_cnt == LAST_DIV) begin
                  div_cnt <= '0;
                  if (bit_cnt == LAST_BIT) state <= S_LATCH;
                  else bit_cnt <= bit_cnt + 1'b1;
               end else begin
                  div_cnt <= div_cnt + 1'b1;
               end
            end
            S_LATCH: begin
               row_select <= row;
               if (step != LAST_STEP) begin
                  step  <= step + 1'b1;
                  state <= S_SETUP;
                  lit   <= 1'b1;
               end else begin
                  step <= '0;
                  if (row != LAST_ROW) begin
                     row   <= row + 1'b1;
                     state <= S_SETUP;
                     lit   <= 1'b1;
                  end else begin
                     // End of frame: enable is only honoured here and in IDLE.
                     row <= '0;
                     lit <= 1'b0;
                     if (enable) begin
                        state      <= S_BRIGHT;
                        brightness <= pending;
                     end else begin
                        state <= S_IDLE;
                     end
                  end
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule
